// File: rtl/reg_file_sb_pkg.sv
// Shared pipeline package: register-file geometry defaults and small helpers
// used by the register file and its issue scoreboard.
package reg_file_sb_pkg;

  localparam int DW_DEF       = 32;
  localparam int AW_DEF       = 5;
  localparam bit ZERO_REG_DEF = 1'b1;

  // An address is writable unless it is the hardwired zero register.
  function automatic logic addr_writable(input logic zero_reg, input logic addr_is_zero);
    return !(zero_reg && addr_is_zero);
  endfunction

endpackage : reg_file_sb_pkg

// File: rtl/reg_file_sb_scoreboard.sv
// Issue scoreboard: one pending bit per register, a registered pending count,
// and per-read-port operand-ready flags that account for writeback bypass.
module rf_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter bit ZERO_REG = ZERO_REG_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic          i_set,
  input  logic [AW-1:0] i_sba,
  input  logic [AW-1:0] i_ra1,
  input  logic [AW-1:0] i_ra2,
  output logic          o_rdy1,
  output logic          o_rdy2,
  output logic [AW:0]   o_pendcnt
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;
  logic [AW:0]      r_cnt;
  logic [AW:0]      w_cnt_nxt;
  logic             w_wr_ok;
  logic             w_set_ok;
  logic             w_inc;
  logic             w_dec;

  assign w_wr_ok  = i_we  && addr_writable(ZERO_REG, (i_wa  == '0));
  assign w_set_ok = i_set && addr_writable(ZERO_REG, (i_sba == '0));

  // Count deltas: a set only counts when the bit was clear; a clear only
  // counts when the bit was set and is not simultaneously re-set.
  always_comb begin
    w_inc = 1'b0;
    w_dec = 1'b0;
    if (w_set_ok && !r_pend[i_sba]) begin
      w_inc = 1'b1;
    end else begin
      w_inc = 1'b0;
    end
    if (w_wr_ok && r_pend[i_wa] && !(w_set_ok && (i_sba == i_wa))) begin
      w_dec = 1'b1;
    end else begin
      w_dec = 1'b0;
    end
  end

  // Next pending vector: clear on writeback first, then set so a new producer wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_ok) begin
      w_pend_nxt[i_wa] = 1'b0;
    end else begin
      w_pend_nxt = r_pend;
    end
    if (w_set_ok) begin
      w_pend_nxt[i_sba] = 1'b1;
    end else begin
      w_pend_nxt[i_sba] = w_pend_nxt[i_sba];
    end
  end

  // Next count: saturating increment/decrement; opposite deltas cancel.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_inc && !w_dec) begin
      if (r_cnt != CNT_MAX) begin
        w_cnt_nxt = r_cnt + (AW+1)'(1);
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else if (w_dec && !w_inc) begin
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - (AW+1)'(1);
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Pending bits and count registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Operand ready: not pending, being bypassed this cycle, or the zero register.
  always_comb begin
    o_rdy1 = 1'b1;
    o_rdy2 = 1'b1;
    if ((ZERO_REG && (i_ra1 == '0)) || (i_we && (i_wa == i_ra1))) begin
      o_rdy1 = 1'b1;
    end else begin
      o_rdy1 = !r_pend[i_ra1];
    end
    if ((ZERO_REG && (i_ra2 == '0)) || (i_we && (i_wa == i_ra2))) begin
      o_rdy2 = 1'b1;
    end else begin
      o_rdy2 = !r_pend[i_ra2];
    end
  end

  assign o_pendcnt = r_cnt;

endmodule : rf_scoreboard

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with same-cycle write bypass, optional
// hardwired zero register, and an issue scoreboard for operand readiness.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter bit ZERO_REG = ZERO_REG_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [AW-1:0] RFRA1,
  input  logic [AW-1:0] RFRA2,
  output logic [DW-1:0] RFRD1,
  output logic [DW-1:0] RFRD2,
  input  logic          RFWE,
  input  logic [AW-1:0] RFWA,
  input  logic [DW-1:0] RFWD,
  input  logic          SBSET,
  input  logic [AW-1:0] SBA,
  output logic          RFRDY1,
  output logic          RFRDY2,
  output logic [AW:0]   PENDCNT
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_regs [DEPTH];
  logic          w_wr_ok;
  logic [DW-1:0] w_rd1;
  logic [DW-1:0] w_rd2;

  assign w_wr_ok = RFWE && addr_writable(ZERO_REG, (RFWA == '0));

  // Register array: asynchronous clear, single write port.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[RFWA] <= RFWD;
    end else begin
      r_regs[RFWA] <= r_regs[RFWA];
    end
  end

  // Read port 1: zero register, then bypass of the in-flight write, then array.
  always_comb begin
    w_rd1 = '0;
    if (ZERO_REG && (RFRA1 == '0)) begin
      w_rd1 = '0;
    end else if (w_wr_ok && (RFWA == RFRA1)) begin
      w_rd1 = RFWD;
    end else begin
      w_rd1 = r_regs[RFRA1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    w_rd2 = '0;
    if (ZERO_REG && (RFRA2 == '0)) begin
      w_rd2 = '0;
    end else if (w_wr_ok && (RFWA == RFRA2)) begin
      w_rd2 = RFWD;
    end else begin
      w_rd2 = r_regs[RFRA2];
    end
  end

  assign RFRD1 = w_rd1;
  assign RFRD2 = w_rd2;

  rf_scoreboard #(
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .i_we      (RFWE),
    .i_wa      (RFWA),
    .i_set     (SBSET),
    .i_sba     (SBA),
    .i_ra1     (RFRA1),
    .i_ra2     (RFRA2),
    .o_rdy1    (RFRDY1),
    .o_rdy2    (RFRDY2),
    .o_pendcnt (PENDCNT)
  );

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a behavioural model (arrays plus population count)
// checked every cycle, plus hand-computed directed expectations.
module tb_reg_file_sb;

  logic        CLK;
  logic        RSTN;
  logic [4:0]  RFRA1, RFRA2, RFWA, SBA;
  logic [31:0] RFRD1, RFRD2, RFWD;
  logic        RFWE, SBSET;
  logic        RFRDY1, RFRDY2;
  logic [5:0]  PENDCNT;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  reg_file_sb dut (
    .CLK(CLK), .RSTN(RSTN),
    .RFRA1(RFRA1), .RFRA2(RFRA2), .RFRD1(RFRD1), .RFRD2(RFRD2),
    .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD),
    .SBSET(SBSET), .SBA(SBA),
    .RFRDY1(RFRDY1), .RFRDY2(RFRDY2), .PENDCNT(PENDCNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model expectations derived from the register-file rules.
  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (RFWE && RFWA == ra) return RFWD;
    return m_regs[ra];
  endfunction

  function automatic logic exp_rdy(input logic [4:0] ra);
    if (ra == 5'd0) return 1'b1;
    if (RFWE && RFWA == ra) return 1'b1;
    return !m_pend[ra];
  endfunction

  function automatic int exp_cnt();
    int s = 0;
    for (int k = 0; k < 32; k++) s += int'(m_pend[k]);
    return s;
  endfunction

  // Model state: cleared by reset, updated at each rising edge (set beats clear).
  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int k = 0; k < 32; k++) begin
        m_regs[k] <= 32'd0;
        m_pend[k] <= 1'b0;
      end
    end else begin
      if (RFWE && RFWA != 5'd0) begin
        m_regs[RFWA] <= RFWD;
        m_pend[RFWA] <= 1'b0;
      end
      if (SBSET && SBA != 5'd0) m_pend[SBA] <= 1'b1;
    end
  end

  // Compare process: every cycle out of reset, on the falling edge.
  always @(negedge CLK) begin
    if (RSTN && chk_en) begin
      chk("model_rd1",  64'(RFRD1),   64'(exp_rd(RFRA1)));
      chk("model_rd2",  64'(RFRD2),   64'(exp_rd(RFRA2)));
      chk("model_rdy1", 64'(RFRDY1),  64'(exp_rdy(RFRA1)));
      chk("model_rdy2", 64'(RFRDY2),  64'(exp_rdy(RFRA2)));
      chk("model_cnt",  64'(PENDCNT), 64'(exp_cnt()));
    end
  end

  task automatic idle();
    RFWE = 1'b0; RFWA = 5'd0; RFWD = 32'd0;
    SBSET = 1'b0; SBA = 5'd0;
    RFRA1 = 5'd0; RFRA2 = 5'd0;
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    RSTN = 1'b0;
    #2;
    chk("rst_rd1",  64'(RFRD1), 64'd0);
    chk("rst_rdy1", 64'(RFRDY1), 64'd1);
    chk("rst_rdy2", 64'(RFRDY2), 64'd1);
    chk("rst_cnt",  64'(PENDCNT), 64'd0);
    #20;
    RSTN = 1'b1;
    chk_en = 1'b1;
    cycle();

    // Write r7, read next cycle.
    RFWE = 1'b1; RFWA = 5'd7; RFWD = 32'hDEADBEEF;
    cycle();
    idle(); RFRA1 = 5'd7;
    #1 chk("r7_read", 64'(RFRD1), 64'hDEADBEEF);

    // Same-cycle bypass on port 2.
    RFWE = 1'b1; RFWA = 5'd3; RFWD = 32'h12345678; RFRA2 = 5'd3;
    #1 chk("bypass_rd2",  64'(RFRD2), 64'h12345678);
    chk("bypass_rdy2", 64'(RFRDY2), 64'd1);
    cycle();

    // Zero register ignores writes and scoreboard sets.
    idle(); RFWE = 1'b1; RFWA = 5'd0; RFWD = 32'hFFFFFFFF; RFRA1 = 5'd0;
    #1 chk("r0_same", 64'(RFRD1), 64'd0);
    cycle();
    idle(); RFRA1 = 5'd0; SBSET = 1'b1; SBA = 5'd0;
    #1 chk("r0_next", 64'(RFRD1), 64'd0);
    cycle();
    idle();
    #1 chk("r0_cnt", 64'(PENDCNT), 64'd0);

    // Pending r5, then clear with a bypassed write.
    SBSET = 1'b1; SBA = 5'd5;
    cycle();
    idle(); RFRA1 = 5'd5;
    #1 chk("r5_rdy0", 64'(RFRDY1), 64'd0);
    chk("r5_cnt1", 64'(PENDCNT), 64'd1);
    RFWE = 1'b1; RFWA = 5'd5; RFWD = 32'h55;
    #1 chk("r5_rdy_byp", 64'(RFRDY1), 64'd1);
    cycle();
    idle();
    #1 chk("r5_cnt0", 64'(PENDCNT), 64'd0);

    // Set and write r9 together while pending: stays pending, data lands.
    SBSET = 1'b1; SBA = 5'd9;
    cycle();
    SBSET = 1'b1; SBA = 5'd9; RFWE = 1'b1; RFWA = 5'd9; RFWD = 32'h99;
    cycle();
    idle(); RFRA1 = 5'd9;
    #1 chk("r9_rdy", 64'(RFRDY1), 64'd0);
    chk("r9_cnt", 64'(PENDCNT), 64'd1);
    chk("r9_data", 64'(RFRD1), 64'h99);
    RFWE = 1'b1; RFWA = 5'd9; RFWD = 32'h9A;
    cycle();

    // Fill every writable register's pending bit.
    for (int a = 1; a < 32; a++) begin
      idle(); SBSET = 1'b1; SBA = 5'(a);
      cycle();
    end
    idle();
    #1 chk("fill_cnt", 64'(PENDCNT), 64'd31);
    SBSET = 1'b1; SBA = 5'd3; RFWE = 1'b1; RFWA = 5'd0; RFWD = 32'h1;
    cycle();
    idle();
    #1 chk("fill_hold", 64'(PENDCNT), 64'd31);
    // Set an already-pending reg while clearing another: net -1.
    SBSET = 1'b1; SBA = 5'd4; RFWE = 1'b1; RFWA = 5'd6; RFWD = 32'h66;
    cycle();
    idle();
    #1 chk("net_dec", 64'(PENDCNT), 64'd30);

    // Mixed directed pattern, checked by the model every cycle.
    for (int i = 0; i < 48; i++) begin
      SBSET = (i % 3) != 0;
      SBA   = 5'((i * 7) % 32);
      RFWE  = (i % 2) == 0;
      RFWA  = 5'((i * 5 + 3) % 32);
      RFWD  = (32'(i) * 32'h01010101) ^ 32'hCAFE0000;
      RFRA1 = 5'((i * 11) % 32);
      RFRA2 = (i % 4 == 0) ? RFWA : 5'((i * 13) % 32);
      cycle();
    end

    // Reset between edges after r1..r4 pending and r2 written.
    idle(); SBSET = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      SBA = 5'(a);
      cycle();
    end
    idle(); RFWE = 1'b1; RFWA = 5'd2; RFWD = 32'hA5;
    cycle();
    idle(); RFRA1 = 5'd2; RFRA2 = 5'd7;
    SBSET = 1'b1; SBA = 5'd6;
    #2 chk_en = 1'b0;
    RSTN = 1'b0;
    #1 chk("mid_rst_rd1",  64'(RFRD1), 64'd0);
    chk("mid_rst_rd2",  64'(RFRD2), 64'd0);
    chk("mid_rst_rdy1", 64'(RFRDY1), 64'd1);
    chk("mid_rst_cnt",  64'(PENDCNT), 64'd0);
    cycle();
    idle(); RFRA1 = 5'd6;
    #2 RSTN = 1'b1;
    #1 chk("post_rst_rdy", 64'(RFRDY1), 64'd1);
    chk("post_rst_cnt", 64'(PENDCNT), 64'd0);
    chk_en = 1'b1;
    SBSET = 1'b1; SBA = 5'd6;
    cycle();
    idle(); RFRA1 = 5'd6;
    #1 chk("post_rst_set", 64'(PENDCNT), 64'd1);
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_file_sb

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DW, default 32, data width of each register.
REQ-002 SHALL have parameter AW, default 5, address width; depth = 2**AW.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads 0 and ignores writes and scoreboard sets.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 CLK  input  1  clock; all state updates on the rising edge.
REQ-006 RSTN  input  1  asynchronous active-low reset.
REQ-007 RFRA1, RFRA2  input  AW  read addresses (rs, rt).
REQ-008 RFRD1, RFRD2  output  DW  read data.
REQ-009 RFWE  input  1  writeback enable.
REQ-010 RFWA  input  AW  writeback address (rd).
REQ-011 RFWD  input  DW  writeback data.
REQ-012 SBSET  input  1  issue strobe: mark SBA as pending a write.
REQ-013 SBA  input  AW  destination register being issued.
REQ-014 RFRDY1, RFRDY2  output  1  operand at RFRA1/RFRA2 is usable this cycle.
REQ-015 PENDCNT  output  AW+1  number of registers currently pending.

Function
REQ-016 Reads SHALL be combinational from the register array: zero-cycle latency.
REQ-017 A write SHALL update reg[RFWA] with RFWD at the rising edge when RFWE=1 and RFWA is writable.
REQ-018 The block SHALL bypass same-cycle writes: if RFWE=1, RFWA=RFRAx and RFWA is writable, RFRDx SHALL equal RFWD.
REQ-019 With ZERO_REG=1, reads of address 0 SHALL return 0, even during a write to address 0.
REQ-020 Each register SHALL have a pending bit; SBSET=1 SHALL set pending[SBA] at the edge.
REQ-021 A write SHALL clear pending[RFWA] at the edge.
REQ-022 If SBSET and RFWE target the same address in one cycle, set SHALL win (new producer), and the data write SHALL still occur.
REQ-023 SBSET on an already-pending register SHALL leave it pending; PENDCNT SHALL not change.
REQ-024 RFRDYx SHALL be 1 when pending[RFRAx]=0, or when RFWE=1 with RFWA=RFRAx (bypassed), or when RFRAx=0 with ZERO_REG=1; otherwise 0.
REQ-025 PENDCNT SHALL be a registered count that always equals the population of the pending bits: +1 on a new set, -1 on a clear of a pending bit, unchanged on set+clear of different pending/non-pending bits that net to zero.
REQ-026 PENDCNT SHALL saturate at 2**AW (all registers pending) and never wrap; a write to a non-pending register SHALL not decrement it.

Reset
REQ-027 RSTN=0 SHALL immediately clear all registers, all pending bits and PENDCNT, independent of CLK.
REQ-028 During and after reset, RFRD1/RFRD2 SHALL be 0 (unless bypassing), RFRDY1/RFRDY2 SHALL be 1 and PENDCNT SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard any write or SBSET in that cycle; the first update occurs at the first rising edge after RSTN rises.

Structure
REQ-030 DW/AW defaults and the ZERO_REG constant SHALL live in the shared pipeline package.
REQ-031 The scoreboard (pending bits, PENDCNT, RFRDY logic) SHALL be one sub-module, rf_scoreboard; the data array and bypass stay in the top level.

Verification
REQ-032 Write 0xDEADBEEF to r7, read RFRA1=7 next cycle -> RFRD1=0xDEADBEEF.
REQ-033 RFWE=1, RFWA=3, RFWD=0x12345678, RFRA2=3 same cycle -> RFRD2=0x12345678, RFRDY2=1.
REQ-034 Write 0xFFFFFFFF to r0, read RFRA1=0 same and next cycle -> RFRD1=0 both cycles, PENDCNT=0 after SBSET to SBA=0.
REQ-035 SBSET SBA=5; next cycle RFRA1=5 -> RFRDY1=0, PENDCNT=1; write r5 -> RFRDY1=1 that cycle, PENDCNT=0 after edge.
REQ-036 SBSET SBA=9 with RFWE RFWA=9 while r9 pending -> r9 remains pending, data written, PENDCNT unchanged.
REQ-037 Set pending on r1..r4, write r2=0xA5, assert RSTN=0 between edges -> all reads 0, RFRDY=1, PENDCNT=0 immediately.
